// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / branch / memory-wait hazard control with timeout FSM
// Freezes, stalls and bubbles the pipe; counts stall cycles with saturation.
module hazard_control_unit #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       if_id_ra,
  input  logic [1:0]       if_id_rb,
  input  logic             if_id_uses_ra,
  input  logic             if_id_uses_rb,
  input  logic             id_ex_mem_read,
  input  logic [1:0]       id_ex_reg_dest,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       hz_state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TIMEOUT  = 2'b10
  } state_t;

  localparam logic [7:0] MAX_WAIT_V = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = id_ex_mem_read &
                     ((if_id_uses_ra & (id_ex_reg_dest == if_id_ra)) |
                      (if_id_uses_rb & (id_ex_reg_dest == if_id_rb)));
  assign hz_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!pc_write_en && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_hold    = 1'b0;
    mem_timeout    = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == MAX_WAIT_V) begin
          state_nxt = TIMEOUT;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      TIMEOUT: ;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase

    // Branch wins over load-use: the dependent consumer is flushed anyway.
    if (state == TIMEOUT) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      ex_mem_hold    = 1'b1;
      mem_timeout    = 1'b1;
    end else if (mem_stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      ex_mem_hold    = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end

    if (rst) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      ex_mem_hold    = 1'b0;
      mem_timeout    = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized bench with behavioural hazard model
// Two instances share stimulus; the narrow-counter one exercises saturation.
module tb_hazard_control_unit;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] if_id_ra, if_id_rb, id_ex_reg_dest;
  logic       if_id_uses_ra, if_id_uses_rb, id_ex_mem_read;
  logic       ex_branch_taken, dmem_req, dmem_ready;

  logic        pc_we, ifid_we, ifid_fl, idex_fl, hold, tmo;
  logic [15:0] cnt;
  logic [1:0]  hz;
  logic        s_pc_we, s_ifid_we, s_ifid_fl, s_idex_fl, s_hold, s_tmo;
  logic [3:0]  s_cnt;
  logic [1:0]  s_hz;

  int n_cmp = 0;
  int n_bad = 0;

  int m_waits = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  hazard_control_unit #(.MAX_WAIT(MAXW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .if_id_ra(if_id_ra), .if_id_rb(if_id_rb),
    .if_id_uses_ra(if_id_uses_ra), .if_id_uses_rb(if_id_uses_rb),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_dest(id_ex_reg_dest),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write_en(pc_we), .if_id_write_en(ifid_we), .if_id_flush(ifid_fl),
    .id_ex_flush(idex_fl), .ex_mem_hold(hold), .mem_timeout(tmo),
    .stall_count(cnt), .hz_state(hz)
  );

  hazard_control_unit #(.MAX_WAIT(MAXW), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .if_id_ra(if_id_ra), .if_id_rb(if_id_rb),
    .if_id_uses_ra(if_id_uses_ra), .if_id_uses_rb(if_id_uses_rb),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_dest(id_ex_reg_dest),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we), .if_id_flush(s_ifid_fl),
    .id_ex_flush(s_idex_fl), .ex_mem_hold(s_hold), .mem_timeout(s_tmo),
    .stall_count(s_cnt), .hz_state(s_hz)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Expected {pc_we, ifid_we, ifid_flush, idex_flush, hold, timeout} from the rules.
  function automatic logic [5:0] model_out();
    bit ms, lu;
    ms = dmem_req && !dmem_ready;
    lu = id_ex_mem_read &&
         ((if_id_uses_ra && id_ex_reg_dest == if_id_ra) ||
          (if_id_uses_rb && id_ex_reg_dest == if_id_rb));
    if (rst)                  return 6'b001100;
    else if (m_to)            return 6'b000011;
    else if (ms)              return 6'b000010;
    else if (ex_branch_taken) return 6'b111100;
    else if (lu)              return 6'b000100;
    else                      return 6'b110000;
  endfunction

  always @(posedge clk) begin
    logic [5:0] e;
    e = model_out();
    if (rst) begin
      m_waits = 0; m_to = 1'b0; m_cnt = 0; m_valid = 1'b1;
    end else begin
      if (!e[5]) m_cnt++;
      if (!m_to) begin
        if (dmem_req && !dmem_ready) begin
          m_waits++;
          if (m_waits > MAXW) m_to = 1'b1;
        end else begin
          m_waits = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    int         hz_e;
    e = model_out();
    chk("pc_write_en", {31'd0, pc_we}, {31'd0, e[5]});
    chk("if_id_write_en", {31'd0, ifid_we}, {31'd0, e[4]});
    chk("if_id_flush", {31'd0, ifid_fl}, {31'd0, e[3]});
    chk("id_ex_flush", {31'd0, idex_fl}, {31'd0, e[2]});
    chk("ex_mem_hold", {31'd0, hold}, {31'd0, e[1]});
    chk("mem_timeout", {31'd0, tmo}, {31'd0, e[0]});
    chk("sat_outputs", {26'd0, s_pc_we, s_ifid_we, s_ifid_fl, s_idex_fl, s_hold, s_tmo},
        {26'd0, e});
    if (m_valid) begin
      hz_e = m_to ? 2 : (m_waits > 0 ? 1 : 0);
      chk("hz_state", {30'd0, hz}, hz_e);
      chk("sat_hz_state", {30'd0, s_hz}, hz_e);
      chk("stall_count", {16'd0, cnt}, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("sat_stall_count", {28'd0, s_cnt}, (m_cnt > 15) ? 15 : m_cnt);
    end
  end

  task automatic set_in(input logic [1:0] ra, input logic [1:0] rb, input logic ua,
                        input logic ub, input logic mr, input logic [1:0] dest,
                        input logic br, input logic req, input logic rdy);
    if_id_ra = ra; if_id_rb = rb; if_id_uses_ra = ua; if_id_uses_rb = ub;
    id_ex_mem_read = mr; id_ex_reg_dest = dest; ex_branch_taken = br;
    dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic rand_in();
    set_in(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic idle();
    set_in(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int thr;
    rst = 1'b1;
    rand_in();
    @(negedge clk);
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_flushes", {30'd0, ifid_fl, idex_fl}, 32'd3);
    chk("rst_hold_tmo", {30'd0, hold, tmo}, 32'd0);
    tick();
    rand_in();
    tick();

    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_hz", {30'd0, hz}, 32'd0);
    chk("post_rst_cnt", {16'd0, cnt}, 32'd0);
    chk("post_rst_pc_we", {31'd0, pc_we}, 32'd1);
    tick();

    set_in(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lu_ctrl", {29'd0, pc_we, ifid_we, idex_fl}, 32'b001);
    tick();
    set_in(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lu_cnt1", {16'd0, cnt}, 32'd1);
    chk("no_lu_pc_we", {31'd0, pc_we}, 32'd1);
    tick();

    set_in(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("br_ctrl", {29'd0, pc_we, ifid_fl, idex_fl}, 32'b111);
    tick();
    idle();
    @(negedge clk);
    chk("br_cnt", {16'd0, cnt}, 32'd1);
    tick();

    for (int i = 0; i < 3; i++) begin
      set_in(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mw_hold", {31'd0, hold}, 32'd1);
      tick();
      chk("mw_hz", {30'd0, hz}, 32'd1);
    end
    set_in(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mw_release_pc", {31'd0, pc_we}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("mw_back_run", {30'd0, hz}, 32'd0);
    chk("mw_cnt", {16'd0, cnt}, 32'd4);
    tick();

    for (int i = 0; i < MAXW + 1; i++) begin
      set_in(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("to_pre_hz", {30'd0, hz}, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    chk("to_hz", {30'd0, hz}, 32'd2);
    set_in(2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("to_sticky", {30'd0, tmo, pc_we}, 32'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("to_cleared", {30'd0, tmo, hz[1]}, 32'd0);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_in(2'd3, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle();
    @(negedge clk);
    chk("sat_cnt15", {28'd0, s_cnt}, 32'd15);
    chk("wide_cnt20", {16'd0, cnt}, 32'd20);
    tick();

    thr = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) thr = $urandom_range(1, 9);
      rand_in();
      dmem_ready = ($urandom_range(0, 9) < thr);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
